// File: rtl/pattern_tx.sv
// pattern_tx: serial frame transmitter.
// Sends a WIDTH-bit word (built-in PATTERN or a custom word) MSB first,
// repeat_cnt+1 times, with GAP idle cycles between consecutive frames.
// Optional feature macro: PATTERN_TX_PARITY_EN appends an even-parity bit
// after every frame.
//
// Handshake: start is a request sampled only while the FSM is in IDLE
// (including the done cycle); a high start at that edge is accepted and
// use_custom/data/repeat_cnt are captured at the same edge. out is a frame
// bit exactly when out_valid is high; there is no backpressure.
module pattern_tx #(
    parameter int                 WIDTH   = 5,
    parameter logic [WIDTH-1:0]   PATTERN = WIDTH'(5'b11010),
    parameter int                 GAP     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_custom,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
    localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_PAR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] word, word_n;
    logic [CW-1:0]    bit_cnt, bit_n;
    logic [3:0]       frames_left, frames_n;
    logic [3:0]       gap_cnt, gap_n;
    logic             done_q, done_n;
    logic             frame_end;

    // State and datapath registers; reset clears everything, including done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            word        <= '0;
            bit_cnt     <= '0;
            frames_left <= '0;
            gap_cnt     <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            word        <= word_n;
            bit_cnt     <= bit_n;
            frames_left <= frames_n;
            gap_cnt     <= gap_n;
            done_q      <= done_n;
        end
    end

    // Next-state logic: bit_cnt counts down to index the word MSB first,
    // so it never needs more than ceil(log2(WIDTH)) bits.
    always_comb begin
        state_n   = state;
        word_n    = word;
        bit_n     = bit_cnt;
        frames_n  = frames_left;
        gap_n     = gap_cnt;
        done_n    = 1'b0;
        frame_end = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    word_n   = use_custom ? data : PATTERN;
                    frames_n = repeat_cnt;
                    bit_n    = LAST_IDX;
                    state_n  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_cnt != '0) begin
                    bit_n = bit_cnt - 1'b1;
                end else begin
`ifdef PATTERN_TX_PARITY_EN
                    state_n = ST_PAR;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            ST_PAR: begin
                frame_end = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    bit_n   = LAST_IDX;
                    state_n = ST_SEND;
                end else begin
                    gap_n = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Frame boundary: repeat the latched word, idle for GAP, or finish.
        if (frame_end) begin
            if (frames_left != 4'd0) begin
                frames_n = frames_left - 4'd1;
                bit_n    = LAST_IDX;
                if (GAP > 0) begin
                    gap_n   = GAP_LOAD;
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_SEND;
                end
            end else begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
        end
    end

    // Outputs decoded from registered state only, so they never follow inputs.
    always_comb begin
        out       = 1'b0;
        out_valid = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_SEND: begin
                out       = word[bit_cnt];
                out_valid = 1'b1;
            end
`ifdef PATTERN_TX_PARITY_EN
            ST_PAR: begin
                out       = ^word;
                out_valid = 1'b1;
            end
`endif
            default: begin
                out       = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign done      = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: scoreboard bench for pattern_tx.
// u0 uses default parameters (GAP=0); u1 uses GAP=2.
// Expected bits are queued with the cycle they must appear in; a monitor
// on the falling edge pops and compares whenever out_valid or done is seen.
module tb_pattern_tx;

`ifdef PATTERN_TX_PARITY_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 5;
`endif

    // Clock and reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start0 = 1'b0, use_custom0 = 1'b0;
    logic [4:0] data0 = '0;
    logic [3:0] rpt0 = '0;
    logic       out0, out_valid0, busy0, done0;
    logic [1:0] state0;

    logic       start1 = 1'b0, use_custom1 = 1'b0;
    logic [4:0] data1 = '0;
    logic [3:0] rpt1 = '0;
    logic       out1, out_valid1, busy1, done1;
    logic [1:0] state1;

    pattern_tx u0 (
        .clk(clk), .reset(reset), .start(start0), .use_custom(use_custom0),
        .data(data0), .repeat_cnt(rpt0), .out(out0), .out_valid(out_valid0),
        .busy(busy0), .done(done0), .state_dbg(state0)
    );

    pattern_tx #(.GAP(2)) u1 (
        .clk(clk), .reset(reset), .start(start1), .use_custom(use_custom1),
        .data(data1), .repeat_cnt(rpt1), .out(out1), .out_valid(out_valid1),
        .busy(busy1), .done(done1), .state_dbg(state1)
    );

    // Scoreboard state
    logic [16:0] bit_q0[$];
    logic [16:0] bit_q1[$];
    logic [15:0] done_q0[$];
    logic [15:0] done_q1[$];
    int errors = 0;
    int checks = 0;
    int det_cnt = 0;
    logic [4:0] det_sr = '0;
    logic [4:0] det_next;
    logic [16:0] e0, e1;
    logic [15:0] d0, d1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bit(input int sel, input int c, input logic b);
        logic [15:0] cc;
        cc = 16'(c);
        if (sel == 0) bit_q0.push_back({cc, b});
        else bit_q1.push_back({cc, b});
    endtask

    // Queue the expected stream: max_bits<0 means the full transmission plus done.
    task automatic expect_tx(input int sel, input logic [4:0] word, input int rpt,
                             input int gap, input int base, input int max_bits);
        int c;
        int n;
        c = base;
        n = 0;
        for (int f = 0; f <= rpt; f++) begin
            for (int i = 4; i >= 0; i--) begin
                if (max_bits < 0 || n < max_bits) push_bit(sel, c, word[i]);
                n++;
                c++;
            end
`ifdef PATTERN_TX_PARITY_EN
            if (max_bits < 0 || n < max_bits) push_bit(sel, c, ^word);
            n++;
            c++;
`endif
            if (f < rpt) c += gap;
        end
        if (max_bits < 0) begin
            if (sel == 0) done_q0.push_back(16'(c));
            else done_q1.push_back(16'(c));
        end
    endtask

    // Driver: called just after a falling edge; one-cycle start pulse.
    task automatic start_tx(input int sel, input logic uc, input logic [4:0] d,
                            input logic [3:0] rpt, input int gap, input int max_bits);
        logic [4:0] w;
        w = uc ? d : 5'b11010;
        expect_tx(sel, w, int'(rpt), gap, cyc + 1, max_bits);
        if (sel == 0) begin
            start0 = 1'b1; use_custom0 = uc; data0 = d; rpt0 = rpt;
        end else begin
            start1 = 1'b1; use_custom1 = uc; data1 = d; rpt1 = rpt;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_drain(input int sel);
        int left;
        for (int i = 0; i < 400; i++) begin
            left = (sel == 0) ? bit_q0.size() + done_q0.size()
                              : bit_q1.size() + done_q1.size();
            if (left == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        left = (sel == 0) ? bit_q0.size() + done_q0.size()
                          : bit_q1.size() + done_q1.size();
        check(sel == 0 ? "u0 drain" : "u1 drain", left, 0);
    endtask

    // Monitor: compare every presented bit and every done pulse.
    always @(negedge clk) begin
        if (out_valid0) begin
            if (bit_q0.size() == 0) begin
                check("u0 unexpected bit", 1, 0);
            end else begin
                e0 = bit_q0.pop_front();
                check("u0 bit", out0, e0[0]);
                check("u0 bit cycle", cyc, e0[16:1]);
                check("u0 busy in frame", busy0, 1);
            end
            det_next = {det_sr[3:0], out0};
            if (det_next == 5'b11010) det_cnt <= det_cnt + 1;
            det_sr <= det_next;
        end else begin
            det_sr <= '0;
        end
        if (done0) begin
            if (done_q0.size() == 0) begin
                check("u0 unexpected done", 1, 0);
            end else begin
                d0 = done_q0.pop_front();
                check("u0 done cycle", cyc, d0);
                check("u0 busy at done", busy0, 0);
                check("u0 valid at done", out_valid0, 0);
            end
        end
        if (out_valid1) begin
            if (bit_q1.size() == 0) begin
                check("u1 unexpected bit", 1, 0);
            end else begin
                e1 = bit_q1.pop_front();
                check("u1 bit", out1, e1[0]);
                check("u1 bit cycle", cyc, e1[16:1]);
            end
        end else if (busy1) begin
            check("u1 gap out", out1, 0);
        end
        if (done1) begin
            if (done_q1.size() == 0) begin
                check("u1 unexpected done", 1, 0);
            end else begin
                d1 = done_q1.pop_front();
                check("u1 done cycle", cyc, d1);
                check("u1 busy at done", busy1, 0);
            end
        end
    end

    // Directed sequence
    initial begin
        int dbase;
        int det_before;

        repeat (2) @(negedge clk);
        check("rst u0 out", out0, 0);
        check("rst u0 valid", out_valid0, 0);
        check("rst u0 busy", busy0, 0);
        check("rst u0 done", done0, 0);
        check("rst u0 state", state0, 0);
        check("rst u1 busy", busy1, 0);
        reset = 1'b0;
        @(negedge clk);

        // Default pattern, single frame
        start_tx(0, 1'b0, 5'b00000, 4'd0, 0, -1);
        wait_drain(0);

        // Custom word, 3 frames, 2-cycle gaps
        start_tx(1, 1'b1, 5'b10011, 4'd2, 2, -1);
        wait_drain(1);

        // Loopback into a 11010 detector: two frames, two detections
        det_before = det_cnt;
        start_tx(0, 1'b0, 5'b00000, 4'd1, 0, -1);
        wait_drain(0);
        check("detections", det_cnt - det_before, 2);

        // Reset on the 3rd bit aborts with no done pulse
        start_tx(0, 1'b0, 5'b00000, 4'd0, 0, 3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort out", out0, 0);
        check("abort valid", out_valid0, 0);
        check("abort busy", busy0, 0);
        check("abort done", done0, 0);
        check("abort pending bits", bit_q0.size(), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        start_tx(0, 1'b1, 5'b10110, 4'd0, 0, -1);
        wait_drain(0);

        // Start and input changes while busy are ignored
        start_tx(0, 1'b1, 5'b10011, 4'd1, 0, -1);
        repeat (3) @(negedge clk);
        start0 = 1'b1; use_custom0 = 1'b0; data0 = 5'b00000; rpt0 = 4'd15;
        @(negedge clk);
        start0 = 1'b0;
        wait_drain(0);

        // Start held through the done cycle: back-to-back frames
        use_custom0 = 1'b1; data0 = 5'b01101; rpt0 = 4'd0;
        dbase = cyc + 1;
        expect_tx(0, 5'b01101, 0, 0, dbase, -1);
        expect_tx(0, 5'b01101, 0, 0, dbase + FLEN + 1, -1);
        start0 = 1'b1;
        while (cyc < dbase + FLEN + 1) @(negedge clk);
        start0 = 1'b0;
        wait_drain(0);

        // Maximum repeat count yields 16 frames
        start_tx(1, 1'b1, 5'b01011, 4'd15, 2, -1);
        wait_drain(1);

`ifdef PATTERN_TX_PARITY_EN
        // Even parity of 10010 is 0
        start_tx(0, 1'b1, 5'b10010, 4'd0, 0, -1);
        wait_drain(0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
